// File: rtl/seq_sorter.sv
// Multi-cycle odd-even transposition sorter: one compare-exchange phase per clock,
// runtime ascending/descending order, swap count, valid/ready on both sides.
module seq_sorter #(
    parameter int unsigned W  = 4,
    parameter int unsigned N  = 4,
    parameter int unsigned SW = $clog2(N*(N-1)/2+1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic            desc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_data,
    output logic [SW-1:0]   out_swaps
);

    localparam int unsigned PW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_e;

    state_e                 state_q, state_d;
    logic [N-1:0][W-1:0]    arr_q, arr_d, phase_arr_c;
    logic [SW-1:0]          swaps_q, swaps_d, phase_swaps_c;
    logic [PW-1:0]          phase_q, phase_d;
    logic                   desc_q, desc_d;
    logic                   last_phase_c;

    assign last_phase_c = (phase_q == PW'(N-1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)     state_d = SORT;
            SORT:    if (last_phase_c) state_d = DONE;
            DONE:    if (out_ready)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // One phase: even phases pair (0,1),(2,3)..., odd phases pair (1,2),(3,4)...
    always_comb begin
        phase_arr_c   = arr_q;
        phase_swaps_c = '0;
        for (int unsigned a = 0; a < N-1; a++) begin
            if ((a % 2 == 1) == phase_q[0]) begin
                if (desc_q ? (arr_q[a] < arr_q[a+1]) : (arr_q[a] > arr_q[a+1])) begin
                    phase_arr_c[a]   = arr_q[a+1];
                    phase_arr_c[a+1] = arr_q[a];
                    phase_swaps_c    = phase_swaps_c + SW'(1);
                end
            end
        end
    end

    // Datapath next-state
    always_comb begin
        arr_d   = arr_q;
        swaps_d = swaps_q;
        phase_d = phase_q;
        desc_d  = desc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    arr_d   = in_data;
                    desc_d  = desc;
                    swaps_d = '0;
                    phase_d = '0;
                end
            end
            SORT: begin
                arr_d   = phase_arr_c;
                swaps_d = swaps_q + phase_swaps_c;
                phase_d = last_phase_c ? '0 : phase_q + PW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_q   <= '0;
            swaps_q <= '0;
            phase_q <= '0;
            desc_q  <= 1'b0;
        end else begin
            arr_q   <= arr_d;
            swaps_q <= swaps_d;
            phase_q <= phase_d;
            desc_q  <= desc_d;
        end
    end

    assign out_data  = arr_q;
    assign out_swaps = swaps_q;

endmodule

// File: tb/tb_seq_sorter.sv
// Scoreboard bench for seq_sorter: directed 4x4-bit cases plus random W=8 N=8 and N=5 traffic.
module tb_seq_sorter;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] swaps;
    } exp_t;

    localparam int NV = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t q5[$];
    bit done8 = 1'b0;
    bit done5 = 1'b0;

    logic        rst4_n, rstr_n;
    logic        in4_valid, in4_ready, in4_desc, out4_valid, out4_ready;
    logic [15:0] in4_data, out4_data;
    logic [2:0]  out4_swaps;
    logic        in8_valid, in8_ready, in8_desc, out8_valid, out8_ready;
    logic [63:0] in8_data, out8_data;
    logic [4:0]  out8_swaps;
    logic        in5_valid, in5_ready, in5_desc, out5_valid, out5_ready;
    logic [39:0] in5_data, out5_data;
    logic [3:0]  out5_swaps;

    seq_sorter #(.W(4), .N(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(in4_valid), .in_ready(in4_ready),
        .in_data(in4_data), .desc(in4_desc), .out_valid(out4_valid), .out_ready(out4_ready),
        .out_data(out4_data), .out_swaps(out4_swaps)
    );
    seq_sorter #(.W(8), .N(8)) u_dut8 (
        .clk(clk), .rst_n(rstr_n), .in_valid(in8_valid), .in_ready(in8_ready),
        .in_data(in8_data), .desc(in8_desc), .out_valid(out8_valid), .out_ready(out8_ready),
        .out_data(out8_data), .out_swaps(out8_swaps)
    );
    seq_sorter #(.W(8), .N(5)) u_dut5 (
        .clk(clk), .rst_n(rstr_n), .in_valid(in5_valid), .in_ready(in5_ready),
        .in_data(in5_data), .desc(in5_desc), .out_valid(out5_valid), .out_ready(out5_ready),
        .out_data(out5_data), .out_swaps(out5_swaps)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: stable insertion sort plus pairwise inversion count
    function automatic void model(input logic [63:0] v, input int n, input int w, input bit d,
                                  output logic [63:0] r, output int inv);
        int e[8];
        int key;
        int j;
        inv = 0;
        for (int k = 0; k < n; k++) e[k] = int'((v >> (k*w)) & ((64'd1 << w) - 64'd1));
        for (int i = 0; i < n; i++)
            for (int m = i + 1; m < n; m++)
                if (d ? (e[i] < e[m]) : (e[i] > e[m])) inv++;
        for (int i = 1; i < n; i++) begin
            key = e[i];
            j = i - 1;
            while (j >= 0 && (d ? (e[j] < key) : (e[j] > key))) begin
                e[j+1] = e[j];
                j--;
            end
            e[j+1] = key;
        end
        r = '0;
        for (int k = 0; k < n; k++) r = r | (64'(e[k]) << (k*w));
    endfunction

    task automatic start4(input logic [15:0] d, input bit ds, input logic [15:0] ed, input int es);
        exp_t e;
        e.data  = 64'(ed);
        e.swaps = 32'(es);
        q4.push_back(e);
        @(negedge clk);
        in4_valid = 1'b1;
        in4_data  = d;
        in4_desc  = ds;
        #1 check("accept_ready", 64'(in4_ready), 64'd1);
        @(negedge clk);
        in4_valid = 1'b0;
    endtask

    // Waits for the result (scrambling inputs meanwhile), optionally holds off out_ready
    task automatic finish4(input string tag, input int hold);
        exp_t e;
        int   lat = 0;
        while (!out4_valid && lat < 20) begin
            in4_desc = ~in4_desc;
            in4_data = ~in4_data;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        e = q4.pop_front();
        for (int c = 0; c < hold; c++) begin
            in4_valid = 1'b1;
            in4_data  = 16'($urandom);
            check({tag, "_hold_data"},  64'(out4_data),  e.data);
            check({tag, "_hold_swaps"}, 64'(out4_swaps), 64'(e.swaps));
            check({tag, "_hold_rdy"},   64'(in4_ready),  64'd0);
            @(negedge clk);
        end
        in4_valid = 1'b0;
        check({tag, "_data"},  64'(out4_data),  e.data);
        check({tag, "_swaps"}, 64'(out4_swaps), 64'(e.swaps));
        check({tag, "_valid"}, 64'(out4_valid), 64'd1);
        out4_ready = 1'b1;
        @(negedge clk);
        out4_ready = 1'b0;
        check({tag, "_post_rdy"},   64'(in4_ready),  64'd1);
        check({tag, "_post_valid"}, 64'(out4_valid), 64'd0);
    endtask

    // Random traffic on the 8x8 instance
    initial begin : rnd8
        exp_t        e;
        logic [63:0] r;
        int          inv;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        in8_valid = 1'b0; in8_data = '0; in8_desc = 1'b0; out8_ready = 1'b0;
        wait (rstr_n === 1'b1);
        while (got < NV && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            in8_valid  = (sent < NV) && ($urandom_range(3) != 0);
            in8_data   = {$urandom, $urandom};
            in8_desc   = 1'($urandom_range(1));
            out8_ready = ($urandom_range(3) != 0);
            #1;
            if (in8_valid && in8_ready) begin
                model(in8_data, 8, 8, in8_desc, r, inv);
                e.data = r; e.swaps = 32'(inv);
                q8.push_back(e);
                sent++;
            end
            if (out8_valid && out8_ready) begin
                if (q8.size() == 0) begin
                    check("n8_unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q8.pop_front();
                    check("n8_data",  out8_data,        e.data);
                    check("n8_swaps", 64'(out8_swaps),  64'(e.swaps));
                end
                got++;
            end
        end
        check("n8_count", 64'(got), 64'(NV));
        done8 = 1'b1;
    end

    // Random traffic on the odd-count instance
    initial begin : rnd5
        exp_t        e;
        logic [63:0] r;
        int          inv;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        in5_valid = 1'b0; in5_data = '0; in5_desc = 1'b0; out5_ready = 1'b0;
        wait (rstr_n === 1'b1);
        while (got < NV && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            in5_valid  = (sent < NV) && ($urandom_range(3) != 0);
            in5_data   = 40'({$urandom, $urandom});
            in5_desc   = 1'($urandom_range(1));
            out5_ready = ($urandom_range(3) != 0);
            #1;
            if (in5_valid && in5_ready) begin
                model(64'(in5_data), 5, 8, in5_desc, r, inv);
                e.data = r; e.swaps = 32'(inv);
                q5.push_back(e);
                sent++;
            end
            if (out5_valid && out5_ready) begin
                if (q5.size() == 0) begin
                    check("n5_unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q5.pop_front();
                    check("n5_data",  64'(out5_data),  e.data);
                    check("n5_swaps", 64'(out5_swaps), 64'(e.swaps));
                end
                got++;
            end
        end
        check("n5_count", 64'(got), 64'(NV));
        done5 = 1'b1;
    end

    initial begin : main
        int t = 0;
        rst4_n = 1'b0; rstr_n = 1'b0;
        in4_valid = 1'b0; in4_data = '0; in4_desc = 1'b0; out4_ready = 1'b0;
        #12;
        check("rst_in_ready",  64'(in4_ready),  64'd1);
        check("rst_out_valid", 64'(out4_valid), 64'd0);
        check("rst_out_data",  64'(out4_data),  64'd0);
        check("rst_out_swaps", 64'(out4_swaps), 64'd0);
        @(negedge clk);
        rst4_n = 1'b1; rstr_n = 1'b1;

        start4(16'h3A17, 1'b0, 16'hA731, 3); finish4("asc_3a17", 0);
        start4(16'h3A17, 1'b1, 16'h137A, 3); finish4("desc_3a17", 0);
        start4(16'h0123, 1'b0, 16'h3210, 6); finish4("asc_0123", 0);
        start4(16'hFEDC, 1'b0, 16'hFEDC, 0); finish4("asc_fedc", 0);
        start4(16'h5555, 1'b0, 16'h5555, 0); finish4("asc_5555", 0);
        start4(16'h5555, 1'b1, 16'h5555, 0); finish4("desc_5555", 0);

        start4(16'h3A17, 1'b0, 16'hA731, 3); finish4("backpressure", 5);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_second_accept", 64'(in4_ready), 64'd1);
        end

        // Abort during phase 2
        start4(16'h3A17, 1'b0, 16'hA731, 3);
        q4.delete();
        @(negedge clk);
        @(negedge clk);
        rst4_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out4_valid), 64'd0);
        check("midrst_out_data",  64'(out4_data),  64'd0);
        check("midrst_out_swaps", 64'(out4_swaps), 64'd0);
        check("midrst_in_ready",  64'(in4_ready),  64'd1);
        @(negedge clk);
        rst4_n = 1'b1;
        start4(16'h0123, 1'b0, 16'h3210, 6); finish4("after_reset", 0);

        while (!(done8 && done5) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        check("random_done", 64'(done8 && done5), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_sorter.md
# seq_sorter

Parametrised, multi-cycle sorter for a packed vector of N unsigned W-bit elements. It uses odd-even transposition, one compare-exchange phase per clock. It generalises the existing combinational 4×4-bit nibble sorter with runtime ascending/descending order, a swap count, and valid/ready handshakes on both sides. It sits between a producer and consumer as a single-slot, non-pipelined sort engine.

## Interface
Parameters:
- W, 4, element width in bits (≥1)
- N, 4, element count (≥2)
- SW, $clog2(N*(N-1)/2+1), width of swap counter (derived, not overridden)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset; asynchronous and active-low
- in_valid  input  1  producer offers in_data/desc
- in_ready  output  1  block accepts a vector this cycle
- in_data  input  N*W  element k at bits [k*W+W-1 : k*W]
- desc  input  1  0 = ascending, 1 = descending; sampled with in_data
- out_valid  output  1  out_data/out_swaps hold a finished result
- out_ready  input  1  consumer takes the result
- out_data  output  N*W  sorted vector, same packing as in_data
- out_swaps  output  SW  number of exchanges performed for this vector

## Operation
- FSM states: IDLE, SORT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: load in_data into the array register, latch desc, clear the swap counter and phase counter, go to SORT.
- SORT:
  - in_ready=0, out_valid=0.
  - Each cycle applies one phase p (phase counter 0..N-1) to the array.
  - Even p compares pairs (0,1),(2,3),…
  - Odd p compares pairs (1,2),(3,4),…
  - Unpaired end elements are unchanged.
- Compare rule, for lower index a and upper index a+1:
  - Ascending: swap iff elem[a] > elem[a+1].
  - Descending: swap iff elem[a] < elem[a+1].
  - Strict compare, so equal elements never swap and the sort is stable.
- Ascending order leaves the smallest element at index 0.
- The swap counter adds the number of exchanges in the phase.
  - Its maximum is N*(N-1)/2, so it cannot overflow SW.
- After phase N-1, go to DONE.
  - N phases always sort fully.
  - There is no early exit, so latency is data-independent.
- DONE:
  - out_valid=1; out_data and out_swaps held stable.
  - On out_valid&&out_ready, go to IDLE.
- in_data/desc changes while not in IDLE are ignored. in_valid is ignored outside IDLE.
- out_data always shows the array register. Its value is defined only while out_valid=1.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_swaps=0, phase counter=0.
- Accept edge E0 is the edge where in_valid&&in_ready.
- Phases execute at edges E1..EN.
- out_valid is high from the cycle after EN, i.e. N cycles after E0.
- Output edge: out_valid&&out_ready. in_ready is 1 in the following cycle.
- With continuous valid/ready, throughput is one vector per N+2 cycles.
- Back-to-back: a new vector cannot be accepted in the same cycle as the result is taken; in_ready rises the cycle after.
- out_ready held low: DONE persists indefinitely, and outputs do not change.
- Reset asserted in SORT or DONE: the result is discarded and outputs return to reset values immediately.
- in_ready and out_valid are decoded from registered state only, with no combinational path from inputs.

## Test plan
- W=4, N=4, in_data=0x3A17 (elements 7,1,A,3), desc=0 -> out_data=0xA731, out_swaps=3, out_valid 4 cycles after accept.
- Same input, desc=1 -> out_data=0x137A, out_swaps=3. Also check that desc toggled during SORT has no effect.
- Edge data:
  - in 0x0123, asc -> 0x3210, out_swaps=6.
  - in 0xFEDC, asc -> 0xFEDC, out_swaps=0.
  - in 0x5555, either mode -> 0x5555, out_swaps=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing in_data.
  - Required: out_data/out_swaps stable, in_ready=0, no second accept.
  - After the handshake, in_ready=1 on the next cycle.
- Reset mid-sort: assert rst_n=0 at phase 2.
  - Required: immediately out_valid=0, out_data=0, in_ready=1.
  - After release, the next vector sorts correctly.
- W=8, N=8 (and N=5 for odd count): 1000 random vectors with random desc, in_valid and out_ready gaps.
  - Compare against a software stable sort.
  - out_swaps must equal the inversion count.
